stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
Downstream consumer of the counter-timer tick. Counts 0.1 s ticks from the upstream timer, which is configured for a 10 Hz tick, into a BCD time value M:SS.T with a maximum of 9:59.9. Provides start/stop, lap-freeze and clear control. Drives the 4-digit seven-segment display mux stage with BCD digits.

Parameters:
MIN_MAX, 9, terminal value of the minutes digit (1..9); count wraps after MIN_MAX:59.9

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset; asynchronous, active-high; clears all state
tick  input  1  one-cycle 10 Hz pulse from the upstream counter-timer; every cycle it is high counts once
start_stop  input  1  one-cycle pulse (pre-debounced); toggles run/pause
lap  input  1  one-cycle pulse; toggles display freeze while running
clear  input  1  one-cycle pulse; zeroes the count when not running
d_tenths  output  4  displayed tenths digit, BCD 0..9
d_sec_ones  output  4  displayed seconds-ones digit, BCD 0..9
d_sec_tens  output  4  displayed seconds-tens digit, BCD 0..5
d_min  output  4  displayed minutes digit, BCD 0..MIN_MAX
running  output  1  high in RUN
lap_active  output  1  high while the display shows the frozen lap value
overflow  output  1  sticky; set when the count wraps

Behaviour:
- Reset: state=IDLE; count, lap registers, lap_active, overflow=0; all d_* = 0; running=0.
- FSM states: IDLE, RUN, PAUSE. running = (state==RUN).
- Input priority per cycle: clear > start_stop > lap.
- IDLE:
  - start_stop -> RUN.
  - clear -> stays IDLE; state is already zeroed.
  - lap ignored.
- RUN:
  - start_stop -> PAUSE.
  - clear ignored.
  - lap toggles lap_active. On 0->1 the lap registers capture the current registered count.
- PAUSE:
  - start_stop -> RUN; lap_active is kept.
  - clear -> IDLE; zeroes count, lap registers, lap_active and overflow.
  - lap -> lap_active=0.
- Counting:
  - Increment occurs when the current state==RUN and tick=1. The new count is visible after that edge (1-cycle latency).
  - A tick in IDLE or PAUSE is ignored.
- Digit chain:
  - tenths 9->0 carries into sec_ones.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min.
  - min MIN_MAX->0 produces the wrap: count becomes 0:00.0, overflow=1 (sticky until clear or rst), counting continues.
- Simultaneous events:
  - start_stop+tick in RUN: the tick is counted on the same edge the FSM enters PAUSE.
  - lap+tick in RUN: lap captures the pre-increment value; the live count increments.
  - clear+start_stop in PAUSE: clear wins -> IDLE.
- Display: d_* = lap_active ? lap registers : live count. This is a pure mux of registered values, with no combinational path from any input to any output.
- Digits never hold a non-BCD value or exceed their terminal value.
- rst asserted mid-RUN: everything returns to the reset values immediately (asynchronous); the next tick after release is ignored because state is IDLE.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, RUN, PAUSE, 2 bits)
  - BCD_W=4
  - TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5
- Sub-module bcd_digit: parameter MAX; ports clk, rst, clr, inc, q[3:0], carry.
  - carry = inc & (q==MAX).
  - Instantiated 4 times, chained inc<-carry.
- Top-level holds the FSM, lap registers, overflow flag and display mux.

Test Plan:
1. rst, start_stop, 10 ticks -> d_* = 0:01.0, running=1, overflow=0; 5 ticks in PAUSE -> value unchanged.
2. Run 599 ticks -> 0:59.9; 1 more tick -> 1:00.0 (full carry chain in one edge).
3. With MIN_MAX=9, run 5999 ticks -> 9:59.9; next tick -> 0:00.0, overflow=1, still running; clear in RUN -> no change; stop, clear -> 0:00.0, overflow=0, IDLE.
4. At 0:03.4, assert lap together with tick:
   - display frozen at 0:03.4, live count advances to 0:03.5;
   - 20 more ticks, then lap -> display shows live 0:05.5, lap_active=0.
5. start_stop coincident with tick at 0:00.7 -> 0:00.8 and running=0 on the same edge; clear+start_stop in PAUSE -> IDLE, 0:00.0.
6. Assert rst asynchronously between clock edges mid-run at 0:02.3 -> outputs 0 before the next edge; a tick right after release leaves 0:00.0.

Source files
------------

// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the BCD stopwatch: state encoding and digit limits.
package stopwatch_bcd_pkg;

  localparam int ST_W  = 2;
  localparam int BCD_W = 4;

  localparam int TENTHS_MAX   = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit that wraps at MAX and reports a carry on the wrapping increment.
module bcd_digit
  import stopwatch_bcd_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_Q = BCD_W'(MAX);

  logic [BCD_W-1:0] r_q;

  // Digit register: synchronous clear, wrap to zero after MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == MAX_Q) ? '0 : r_q + 1'b1;
    end
  end

  assign q     = r_q;
  assign carry = inc & (r_q == MAX_Q);

endmodule

// File: rtl/stopwatch_bcd.sv
// M:SS.T stopwatch counting 10 Hz ticks, with run/pause, lap freeze and clear.
//   state | meaning
//   IDLE  | count zeroed, waiting for start
//   RUN   | ticks advance the count; lap toggles display freeze
//   PAUSE | count held; clear returns to IDLE, lap releases freeze
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int MIN_MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  output logic [BCD_W-1:0] d_tenths,
  output logic [BCD_W-1:0] d_sec_ones,
  output logic [BCD_W-1:0] d_sec_tens,
  output logic [BCD_W-1:0] d_min,
  output logic             running,
  output logic             lap_active,
  output logic             overflow
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_inc;
  logic w_clr;
  logic w_lap_cap;
  logic w_lap_act_nxt;

  logic w_c_tenths, w_c_sec_ones, w_c_sec_tens, w_c_min;
  logic [BCD_W-1:0] w_tenths, w_sec_ones, w_sec_tens, w_min;
  logic [BCD_W-1:0] r_lap_tenths, r_lap_sec_ones, r_lap_sec_tens, r_lap_min;
  logic r_lap_active;
  logic r_overflow;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and control decode; clear outranks start_stop, which outranks lap.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr         = 1'b0;
    w_lap_cap     = 1'b0;
    w_lap_act_nxt = r_lap_active;
    case (r_state)
      IDLE: begin
        if (clear)           w_clr       = 1'b1;
        else if (start_stop) w_state_nxt = RUN;
      end
      RUN: begin
        if (start_stop) begin
          w_state_nxt = PAUSE;
        end else if (lap) begin
          w_lap_cap     = ~r_lap_active;
          w_lap_act_nxt = ~r_lap_active;
        end
      end
      PAUSE: begin
        if (clear) begin
          w_state_nxt   = IDLE;
          w_clr         = 1'b1;
          w_lap_act_nxt = 1'b0;
        end else if (start_stop) begin
          w_state_nxt = RUN;
        end else if (lap) begin
          w_lap_act_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_clr         = 1'b1;
        w_lap_act_nxt = 1'b0;
      end
    endcase
  end

  assign w_inc = (r_state == RUN) & tick;

  bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_inc),
    .q(w_tenths), .carry(w_c_tenths)
  );

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_c_tenths),
    .q(w_sec_ones), .carry(w_c_sec_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_c_sec_ones),
    .q(w_sec_tens), .carry(w_c_sec_tens)
  );

  bcd_digit #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_c_sec_tens),
    .q(w_min), .carry(w_c_min)
  );

  // Lap snapshot takes the pre-increment count on the freeze edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_tenths   <= '0;
      r_lap_sec_ones <= '0;
      r_lap_sec_tens <= '0;
      r_lap_min      <= '0;
    end else if (w_clr) begin
      r_lap_tenths   <= '0;
      r_lap_sec_ones <= '0;
      r_lap_sec_tens <= '0;
      r_lap_min      <= '0;
    end else if (w_lap_cap) begin
      r_lap_tenths   <= w_tenths;
      r_lap_sec_ones <= w_sec_ones;
      r_lap_sec_tens <= w_sec_tens;
      r_lap_min      <= w_min;
    end
  end

  // Lap freeze flag and sticky wrap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_lap_active <= w_lap_act_nxt;
      if (w_clr)        r_overflow <= 1'b0;
      else if (w_c_min) r_overflow <= 1'b1;
    end
  end

  assign d_tenths   = r_lap_active ? r_lap_tenths   : w_tenths;
  assign d_sec_ones = r_lap_active ? r_lap_sec_ones : w_sec_ones;
  assign d_sec_tens = r_lap_active ? r_lap_sec_tens : w_sec_tens;
  assign d_min      = r_lap_active ? r_lap_min      : w_min;
  assign running    = (r_state == RUN);
  assign lap_active = r_lap_active;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd against a tenths-count reference model.
module tb_stopwatch_bcd;

  localparam int MIN_MAX = 9;
  localparam int LIMIT   = (MIN_MAX + 1) * 600;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] d_tenths, d_sec_ones, d_sec_tens, d_min;
  logic       running, lap_active, overflow;

  int total = 0;
  int bad   = 0;

  // reference model: elapsed time in tenths, plus control flags
  int m_t = 0, m_lapv = 0, m_state = M_IDLE;
  bit m_la = 1'b0, m_ov = 1'b0;

  logic [18:0] exp_q[$];

  stopwatch_bcd #(.MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .lap(lap), .clear(clear),
    .d_tenths(d_tenths), .d_sec_ones(d_sec_ones), .d_sec_tens(d_sec_tens),
    .d_min(d_min), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits(input int t);
    int s;
    s = (t / 10) % 60;
    return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {d_min, d_sec_tens, d_sec_ones, d_tenths, running, lap_active, overflow};
  endfunction

  function automatic logic [18:0] model_vec();
    return {digits(m_la ? m_lapv : m_t), (m_state == M_RUN), m_la, m_ov};
  endfunction

  // monitor: after each rising edge, compare the DUT against the oldest expectation
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (dut_vec() !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t got=%h want=%h", $time, dut_vec(), e);
        end
      end
    end
  end

  // one clock edge: drive inputs, advance model, queue expectation; ends on a falling edge
  task automatic cycle(input bit tk, input bit ss, input bit lp, input bit cl);
    bit inc;
    tick = tk; start_stop = ss; lap = lp; clear = cl;
    inc = (m_state == M_RUN) && tk;
    case (m_state)
      M_IDLE:  if (!cl && ss) m_state = M_RUN;
      M_RUN: begin
        if (ss) m_state = M_PAUSE;
        else if (lp) begin
          if (!m_la) m_lapv = m_t;
          m_la = !m_la;
        end
      end
      default: begin
        if (cl) begin
          m_state = M_IDLE; m_t = 0; m_lapv = 0; m_la = 0; m_ov = 0;
        end else if (ss) m_state = M_RUN;
        else if (lp) m_la = 0;
      end
    endcase
    if (inc) begin
      m_t = m_t + 1;
      if (m_t == LIMIT) begin
        m_t = 0;
        m_ov = 1;
      end
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
    tick = 0; start_stop = 0; lap = 0; clear = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
  endtask

  // directed check against hand-derived constants
  task automatic chk(input string nm, input int m, input int st, input int so, input int te,
                     input bit run, input bit la, input bit ov);
    logic [18:0] want;
    want = {4'(m), 4'(st), 4'(so), 4'(te), run, la, ov};
    total++;
    if (dut_vec() !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, dut_vec(), want);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_lapv = 0; m_state = M_IDLE; m_la = 0; m_ov = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_vals", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: basic count and pause hold
    cycle(0, 1, 0, 0);
    ticks(10);
    chk("one_sec", 0, 0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    ticks(5);
    chk("pause_hold", 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("clear_pause", 0, 0, 0, 0, 0, 0, 0);

    // 2: full carry into minutes
    cycle(0, 1, 0, 0);
    ticks(599);
    chk("t_59_9", 0, 5, 9, 9, 1, 0, 0);
    ticks(1);
    chk("t_1_00_0", 1, 0, 0, 0, 1, 0, 0);

    // 3: wrap, overflow, clear ignored in run
    ticks(5399);
    chk("t_9_59_9", 9, 5, 9, 9, 1, 0, 0);
    ticks(1);
    chk("wrap", 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    chk("clear_in_run", 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    chk("stop_clear", 0, 0, 0, 0, 0, 0, 0);

    // 4: lap with coincident tick
    cycle(0, 1, 0, 0);
    ticks(34);
    cycle(1, 0, 1, 0);
    chk("lap_freeze", 0, 0, 3, 4, 1, 1, 0);
    ticks(20);
    chk("lap_held", 0, 0, 3, 4, 1, 1, 0);
    cycle(0, 0, 1, 0);
    chk("lap_release", 0, 0, 5, 5, 1, 0, 0);

    // 5: stop with tick, then clear beats start
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    ticks(7);
    cycle(1, 1, 0, 0);
    chk("stop_tick", 0, 0, 0, 8, 0, 0, 0);
    cycle(0, 1, 0, 1);
    chk("clear_wins", 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("still_idle", 0, 0, 0, 0, 0, 0, 0);

    // 6: asynchronous reset mid-run
    cycle(0, 1, 0, 0);
    ticks(23);
    chk("t_2_3", 0, 0, 2, 3, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 0, 0);
    chk("tick_after_rst", 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end
    // long run to exercise wrap under random lap activity
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 6500; i++) begin
      cycle(1, 1'b0, ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
